muldiv_engine: RTL and testbench

Parametrised multi-cycle multiply/divide engine for the EX stage, replacing the in-stage mul/div start and finish bookkeeping with a self-contained unit. It has a valid/ready request and response handshake and a tag that travels with each operation. It supports flush-cancel, has configurable data width and divider radix, and returns fixed results for divide-by-zero. It holds one operation in flight and sits between dispatch operands and the EX result mux.

---
 rtl/muldiv_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_muldiv_engine.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_engine.sv
// Multi-cycle multiply/divide engine with valid/ready request and response handshakes.
// Holds one operation in flight; divides use restoring division on operand magnitudes.
module muldiv_engine #(
  parameter int DATA_WIDTH         = 32,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int MUL_LATENCY        = 2,
  parameter int TAG_WIDTH          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_src1,
  input  logic [DATA_WIDTH-1:0] req_src2,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  busy
);

  localparam int DW        = DATA_WIDTH;
  localparam int DIV_ITERS = DATA_WIDTH / DIV_BITS_PER_CYCLE;
  localparam int MAX_COUNT = (DIV_ITERS > MUL_LATENCY) ? DIV_ITERS : MUL_LATENCY;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  // The first divide step happens on the accept edge, so DIV runs DIV_ITERS-1 cycles.
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_ITERS - 2);

  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_MULH  = 3'd2;
  localparam logic [2:0] OP_MULHU = 3'd3;

  if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("muldiv_engine: DATA_WIDTH must be even and at least 8");
  end
  if ((DIV_BITS_PER_CYCLE != 1 && DIV_BITS_PER_CYCLE != 2) ||
      (DATA_WIDTH % DIV_BITS_PER_CYCLE) != 0) begin : g_bad_radix
    $error("muldiv_engine: DIV_BITS_PER_CYCLE must be 1 or 2 and divide DATA_WIDTH");
  end
  if (MUL_LATENCY < 1) begin : g_bad_latency
    $error("muldiv_engine: MUL_LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [DW-1:0]          a_q, a_d;
  logic [DW-1:0]          b_q, b_d;
  logic [DW-1:0]          rem_q, rem_d;
  logic [DW-1:0]          result_q, result_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;

  logic                   accept;
  logic                   req_is_mul;
  logic                   req_is_div;
  logic                   div_by_zero;
  logic                   src1_neg;
  logic                   src2_neg;
  logic [DW-1:0]          mag1;
  logic [DW-1:0]          mag2;
  logic [DW-1:0]          zero_result;

  logic [2:0]             mul_op;
  logic [DW-1:0]          mul_a;
  logic [DW-1:0]          mul_b;
  logic                   mul_signed;
  logic [2*DW-1:0]        mul_a_ext;
  logic [2*DW-1:0]        mul_b_ext;
  logic [2*DW-1:0]        product;
  logic [DW-1:0]          mul_result;

  logic [DW-1:0]          step_rem;
  logic [DW-1:0]          step_quo;
  logic [DW-1:0]          step_div;
  logic [DW:0]            trial;
  logic [DW:0]            diff;

  logic [DW-1:0]          quo_fixed;
  logic [DW-1:0]          rem_fixed;
  logic [DW-1:0]          div_result;

  assign accept      = req_valid && req_ready;
  assign req_is_mul  = (req_op == OP_MUL) || (req_op == OP_MULH) || (req_op == OP_MULHU);
  assign req_is_div  = req_op[2];
  assign div_by_zero = (req_src2 == '0);
  assign src1_neg    = req_is_div && !req_op[0] && req_src1[DW-1];
  assign src2_neg    = req_is_div && !req_op[0] && req_src2[DW-1];
  assign mag1        = src1_neg ? -req_src1 : req_src1;
  assign mag2        = src2_neg ? -req_src2 : req_src2;
  assign zero_result = req_op[1] ? req_src1 : '1;

  // One shared multiplier: fed straight from the request only when MUL_LATENCY is 1.
  assign mul_op     = (state_q == S_IDLE) ? req_op   : op_q;
  assign mul_a      = (state_q == S_IDLE) ? req_src1 : a_q;
  assign mul_b      = (state_q == S_IDLE) ? req_src2 : b_q;
  assign mul_signed = (mul_op == OP_MULH);
  assign mul_a_ext  = {{DW{mul_signed & mul_a[DW-1]}}, mul_a};
  assign mul_b_ext  = {{DW{mul_signed & mul_b[DW-1]}}, mul_b};
  assign product    = mul_a_ext * mul_b_ext;
  assign mul_result = (mul_op == OP_MUL) ? product[DW-1:0] : product[2*DW-1:DW];

  // Restoring divide: the borrow out of trial-divisor decides each quotient bit.
  always_comb begin
    step_rem = (state_q == S_IDLE) ? '0   : rem_q;
    step_quo = (state_q == S_IDLE) ? mag1 : a_q;
    step_div = (state_q == S_IDLE) ? mag2 : b_q;
    trial    = '0;
    diff     = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      trial    = {step_rem, step_quo[DW-1]};
      diff     = trial - {1'b0, step_div};
      step_rem = diff[DW] ? trial[DW-1:0] : diff[DW-1:0];
      step_quo = {step_quo[DW-2:0], ~diff[DW]};
    end
  end

  assign quo_fixed  = neg_quo_q ? -a_q   : a_q;
  assign rem_fixed  = neg_rem_q ? -rem_q : rem_q;
  assign div_result = op_q[1] ? rem_fixed : quo_fixed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && req_is_mul) begin
          state_d = (MUL_LATENCY == 1) ? S_DONE : S_MUL;
        end else if (accept && req_is_div) begin
          state_d = div_by_zero ? S_DONE : S_DIV;
        end
      end
      S_MUL:   if (cnt_q == '0) state_d = S_DONE;
      S_DIV:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (req_is_mul || req_is_div)) begin
          op_d      = req_op;
          tag_d     = req_tag;
          neg_quo_d = src1_neg ^ src2_neg;
          neg_rem_d = src1_neg;
          if (req_is_mul) begin
            cnt_d = MUL_CNT_INIT;
            a_d   = req_src1;
            b_d   = req_src2;
            if (MUL_LATENCY == 1) begin
              result_d = mul_result;
            end
          end else if (div_by_zero) begin
            result_d = zero_result;
          end else begin
            cnt_d = DIV_CNT_INIT;
            a_d   = step_quo;
            b_d   = mag2;
            rem_d = step_rem;
          end
        end
      end
      S_MUL: begin
        result_d = mul_result;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      S_DIV: begin
        a_d   = step_quo;
        rem_d = step_rem;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIX:   result_d = div_result;
      default: ;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE) && !flush && !rst;
    resp_valid = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    resp_data  = result_q;
    resp_tag   = tag_q;
  end

endmodule

// File: tb/tb_muldiv_engine.sv
// Self-checking bench for muldiv_engine: spec vectors, model-checked random ops,
// and hand sequences for back-pressure, flush, reset and radix-2 latency.
module tb_muldiv_engine;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_src1;
  logic [DW-1:0] req_src2;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [TW-1:0] resp_tag;
  logic          busy;

  logic          req_valid_2;
  logic          req_ready_2;
  logic [2:0]    req_op_2;
  logic [DW-1:0] req_src1_2;
  logic [DW-1:0] req_src2_2;
  logic [TW-1:0] req_tag_2;
  logic          resp_valid_2;
  logic [DW-1:0] resp_data_2;
  logic [TW-1:0] resp_tag_2;
  logic          busy_2;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            lat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  muldiv_engine #(
    .DATA_WIDTH(DW), .DIV_BITS_PER_CYCLE(1), .MUL_LATENCY(ML), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  muldiv_engine #(
    .DATA_WIDTH(DW), .DIV_BITS_PER_CYCLE(2), .MUL_LATENCY(ML), .TAG_WIDTH(TW)
  ) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .req_valid(req_valid_2), .req_ready(req_ready_2), .req_op(req_op_2),
    .req_src1(req_src1_2), .req_src2(req_src2_2), .req_tag(req_tag_2),
    .resp_valid(resp_valid_2), .resp_ready(1'b1),
    .resp_data(resp_data_2), .resp_tag(resp_tag_2), .busy(busy_2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_result(input logic [2:0] op,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
    logic [63:0] pu;
    longint      ps;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    pu = {32'd0, a} * {32'd0, b};
    ps = longint'(sa) * longint'(sb);
    case (op)
      3'd1: return pu[31:0];
      3'd2: return ps[63:32];
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return sa % sb;
      end
      3'd7: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [DW-1:0] b);
    if (op[2]) return (b == 0) ? 1 : DW + 1;
    return ML;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [TW-1:0] tag,
                               input logic [DW-1:0] data, input int lat);
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_tag   = tag;
    req_valid = 1'b1;
    #1;
    for (int w = 0; w < 100 && !req_ready; w++) begin
      @(negedge clk);
      #1;
    end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
    end else begin
      sb_q.push_back('{data, tag, lat, cyc});
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_src1  = $urandom;
    req_src2  = $urandom;
    req_tag   = TW'($urandom_range(0, 15));
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    for (int n = 0; n < 100 && !resp_valid; n++) @(negedge clk);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      if (!resp_valid) begin
        check({name, "_timeout"}, resp_valid, 1);
      end else begin
        check({name, "_data"}, resp_data, e.data);
        check({name, "_tag"}, resp_tag, e.tag);
        check({name, "_latency"}, cyc - e.acc, e.lat);
      end
    end
  endtask

  task automatic run_dut2(input logic [2:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TW-1:0] tag,
                          input logic [DW-1:0] data, input string name);
    int acc;
    @(negedge clk);
    req_op_2    = op;
    req_src1_2  = a;
    req_src2_2  = b;
    req_tag_2   = tag;
    req_valid_2 = 1'b1;
    #1;
    for (int w = 0; w < 100 && !req_ready_2; w++) begin
      @(negedge clk);
      #1;
    end
    acc = cyc;
    @(negedge clk);
    req_valid_2 = 1'b0;
    req_src1_2  = $urandom;
    for (int n = 0; n < 100 && !resp_valid_2; n++) @(negedge clk);
    check({name, "_valid"}, resp_valid_2, 1);
    check({name, "_data"}, resp_data_2, data);
    check({name, "_tag"}, resp_tag_2, tag);
    check({name, "_latency"}, cyc - acc, DW / 2 + 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            first_acc;
    int            stale;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    rst         = 1'b1;
    flush       = 1'b0;
    req_valid   = 1'b0;
    req_op      = '0;
    req_src1    = '0;
    req_src2    = '0;
    req_tag     = '0;
    resp_ready  = 1'b1;
    req_valid_2 = 1'b0;
    req_op_2    = '0;
    req_src1_2  = '0;
    req_src2_2  = '0;
    req_tag_2   = '0;

    vecs.push_back('{3'd1, 32'h0000_0003, 32'hFFFF_FFFE, 4'd5,  32'hFFFF_FFFA, 2});
    vecs.push_back('{3'd2, 32'h0000_0003, 32'hFFFF_FFFE, 4'd6,  32'hFFFF_FFFF, 2});
    vecs.push_back('{3'd3, 32'h0000_0003, 32'hFFFF_FFFE, 4'd7,  32'h0000_0002, 2});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'd1,  32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 4'd2,  32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 4'd3,  32'h7FFF_FFFC, 33});
    vecs.push_back('{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 4'd4,  32'h0000_0001, 33});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8,  32'h8000_0000, 33});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9,  32'h0000_0000, 33});
    vecs.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 4'd10, 32'hFFFF_FFFF, 1});
    vecs.push_back('{3'd7, 32'h0000_0005, 32'h0000_0000, 4'd11, 32'h0000_0005, 1});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 4'd12, 32'hFFFF_FFF9, 1});
    vecs.push_back('{3'd4, 32'h0000_0064, 32'hFFFF_FFF9, 4'd13, 32'hFFFF_FFF2, 33});
    vecs.push_back('{3'd6, 32'h0000_0064, 32'hFFFF_FFF9, 4'd14, 32'h0000_0002, 33});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'h8000_0000, 4'd15, 32'h4000_0000, 2});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0,  32'hFFFF_FFFE, 2});

    repeat (3) @(negedge clk);
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_resp_data", resp_data, 0);
    check("reset_resp_tag", resp_tag, 0);
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", req_ready, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].op, vecs[i].src1, vecs[i].src2, vecs[i].tag,
                    vecs[i].data, vecs[i].lat);
      checkOutput($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(1, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = DW'($urandom_range(1, 20));
      @(negedge clk);
      applyStimulus(op, a, b, TW'(i), model_result(op, a, b), model_lat(op, b));
      checkOutput($sformatf("rand%0d_op%0d", i, op));
    end

    // Response back-pressure holds the result and blocks new requests.
    @(negedge clk);
    resp_ready = 1'b0;
    applyStimulus(3'd1, 32'd7, 32'd9, 4'd11, 32'd63, 2);
    checkOutput("bp_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_op    = 3'd5;
      req_src2  = 32'd3;
      req_valid = 1'b1;
      #1;
      check($sformatf("bp_hold%0d_valid", i), resp_valid, 1);
      check($sformatf("bp_hold%0d_data", i), resp_data, 32'd63);
      check($sformatf("bp_hold%0d_tag", i), resp_tag, 4'd11);
      check($sformatf("bp_hold%0d_req_ready", i), req_ready, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_req_ready", req_ready, 1);
    check("bp_release_resp_valid", resp_valid, 0);

    // Flush mid-divide, with a competing request on the flush cycle.
    @(negedge clk);
    applyStimulus(3'd5, 32'd1000, 32'd3, 4'd3, 32'd333, 33);
    first_acc = sb_q[0].acc;
    void'(sb_q.pop_front());
    while (cyc < first_acc + 10) @(negedge clk);
    flush     = 1'b1;
    req_op    = 3'd1;
    req_src1  = 32'd2;
    req_src2  = 32'd2;
    req_tag   = 4'd12;
    req_valid = 1'b1;
    #1;
    check("flush_req_ready", req_ready, 0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_busy", busy, 0);
    check("flush_resp_valid", resp_valid, 0);
    applyStimulus(3'd5, 32'd100, 32'd7, 4'd9, 32'd14, 33);
    check("flush_next_accept_cycle", sb_q[0].acc - first_acc, 11);
    checkOutput("flush_divu");

    // Reset mid-divide abandons the operation.
    @(negedge clk);
    applyStimulus(3'd4, 32'hFFFF_0000, 32'd3, 4'd13, 32'd0, 33);
    sb_q.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req_ready_in_reset", req_ready, 0);
    @(negedge clk);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_data", resp_data, 0);
    check("midrst_resp_tag", resp_tag, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("midrst_req_ready_after", req_ready, 1);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) stale++;
    end
    check("midrst_stale_responses", stale, 0);

    // An accepted op code of 0 is dropped without leaving IDLE.
    @(negedge clk);
    req_op    = 3'd0;
    req_src1  = 32'd4;
    req_src2  = 32'd4;
    req_tag   = 4'd2;
    req_valid = 1'b1;
    #1;
    check("op0_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("op0_busy", busy, 0);
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) stale++;
    end
    check("op0_no_response", stale, 0);

    run_dut2(3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 4'd6, 32'h0FFF_FFFF, "r2_divu");
    run_dut2(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 4'd7, 32'hFFFF_FFFD, "r2_div");
    run_dut2(3'd6, 32'h0000_0064, 32'hFFFF_FFF9, 4'd8, 32'h0000_0002, "r2_mod");

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
